hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised operand-hazard unit for the decode stage; successor to the fixed two-port, two-source forwarding logic.
- Keeps a per-register pending table with latency countdowns for multi-cycle producers (loads, mult/div, CP0 reads).
- Selects bypass data from NBYP in-flight stages for NREAD source ports.
- Raises a single decode stall when any source is not yet obtainable.

Parameters:
NREAD, 2, number of register-read ports
NBYP, 2, number of bypass sources; index 0 is the youngest (execute), then memory, and so on
REG_AW, 5, register address width; register 0 is hard-wired to zero
DW, 32, data width
LAT_W, 3, width of the latency countdown (max latency 2^LAT_W-1)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush  in  1  pipeline redirect; clears the pending table
issue_valid  in  1  decode holds a valid instruction
issue_wen  in  1  the instruction writes a GPR
issue_waddr  in  REG_AW  destination register
issue_lat  in  LAT_W  cycles after issue until the result is bypassable (0 = bypassable next cycle)
ra  in  NREAD*REG_AW  source addresses
rf_data  in  NREAD*DW  register-file read data
byp_valid  in  NBYP  stage holds a register-writing instruction
byp_addr  in  NBYP*REG_AW  stage destination
byp_data  in  NBYP*DW  stage result
byp_ready  in  NBYP  byp_data is final (0 for a load still in execute)
wb_valid  in  1  register-file write this cycle
wb_addr  in  REG_AW  register-file write address
opnd  out  NREAD*DW  forwarded operands
stall  out  1  decode must hold
issue_fire  out  1  issue_valid & ~stall

Behaviour:
Operand selection (combinational, per port p):
- ra[p]==0 gives opnd=0, no hazard.
- Otherwise scan bypass sources from index 0 upward; the first i with byp_valid[i] & byp_addr[i]==ra[p] wins.
  - byp_ready[i]=1: opnd=byp_data[i].
  - byp_ready[i]=0: hazard.
- No bypass match:
  - pend[ra]=1 and cnt[ra]!=0: hazard.
  - Otherwise opnd=rf_data[p]. The register file is write-through, so a same-cycle wb to ra is already reflected.

Stall and issue:
- stall = issue_valid & (hazard on any port). Combinational; no registered latency.

Pending table: pend[2^REG_AW] bits and cnt[2^REG_AW] of LAT_W bits.
- Each cycle, every cnt!=0 decrements by 1; saturates at 0.
- On issue_fire & issue_wen & issue_waddr!=0: pend[waddr]<=1, cnt[waddr]<=issue_lat. This overrides the decrement and the wb clear for that entry.
- On wb_valid & wb_addr!=0: pend[wb_addr]<=0, unless the same address is issued this cycle.
- Entry 0 is never set.
- flush: all pend and cnt cleared next cycle; the same-cycle issue is ignored (issue_fire is still reported). The pipeline asserts flush only when no older multi-cycle producer is uncommitted.

Reset and boundaries:
- Reset (async, resetn=0): pend=0, cnt=0; outputs are combinational. With issue_valid=0, stall=0.
- Reset mid-operation discards all pending state.
- Re-issue to a pending register restarts its countdown (WAW: the youngest writer wins).
- issue_lat at its maximum value is accepted without wrap.

Optional Feature:
HILO_TRACK_EN
- Defined:
  - Adds two pseudo-registers, HI and LO.
  - Adds inputs issue_hi_w, issue_lo_w, wb_hi, wb_lo, and per-port read-select bits rd_hi and rd_lo.
  - The same pend/cnt rules apply; a multiply or divide with issue_lat up to 2^LAT_W-1 stalls a following MFHI/MFLO until its countdown expires or a ready bypass matches.
  - Bypass entries carry byp_hi and byp_lo flags.
- Undefined: none of these ports exist; HI/LO hazards are the pipeline's responsibility.

Decomposition:
- Shared package (pipeline package): reg_addr_t, word_t, lat_t, and the constant REG_ZERO.
- One sub-module, pend_entry: pend bit, countdown, and set/clear/flush priority. Instantiated per register with a generate loop.
- Bypass priority mux is inline.

Test Plan:
1. Back-to-back dependence: execute writes r3=0x11 with byp_ready=1; decode reads r3 -> stall=0, opnd=0x11.
2. Load-use: execute load to r5 with byp_ready=0; decode reads r5 -> stall=1 for one cycle, then memory bypass supplies 0xDEAD and stall=0.
3. Long latency: issue r7 with lat=5 -> reader of r7 stalls 5 cycles, then sees rf_data or bypass data.
4. Simultaneous wb and issue to r9 -> pend[9] stays 1, cnt=issue_lat.
5. Register 0: ra=0 while execute writes r0 -> opnd=0, stall=0.
6. flush with r2 and r4 pending, then async reset pulse mid-countdown -> both clear; readers of r2 and r4 get stall=0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline types for the decode-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int DW_DEF     = 32;
  localparam int LAT_W_DEF  = 3;

  typedef logic [REG_AW_DEF-1:0] reg_addr_t;
  typedef logic [DW_DEF-1:0]     word_t;
  typedef logic [LAT_W_DEF-1:0]  lat_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/hazard_scoreboard_pend_entry.sv
// One pending-table entry: pend bit plus latency countdown.
// Priority, highest first: flush, issue (set), writeback clear, decrement.
module pend_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             set_i,
  input  logic [LAT_W-1:0] lat_i,
  input  logic             clr_i,
  output logic             pend_o,
  output logic [LAT_W-1:0] cnt_o
);

  logic             pend_q, pend_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every next-state value gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    pend_d = pend_q;
    cnt_d  = (cnt_q != '0) ? cnt_q - LAT_W'(1) : cnt_q;
    if (clr_i) begin
      pend_d = 1'b0;
    end
    if (set_i) begin
      pend_d = 1'b1;
      cnt_d  = lat_i;
    end
    if (flush_i) begin
      pend_d = 1'b0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments for state so every flop samples pre-edge values regardless of block order.
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_o = pend_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage operand hazard unit: pending table, bypass select, stall.
// Optional HI/LO pseudo-register tracking is enabled by defining HILO_TRACK_EN.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREAD  = 2,
  parameter int NBYP   = 2,
  parameter int REG_AW = REG_AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int LAT_W  = LAT_W_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   issue_valid,
  input  logic                   issue_wen,
  input  logic [REG_AW-1:0]      issue_waddr,
  input  logic [LAT_W-1:0]       issue_lat,
  input  logic [NREAD*REG_AW-1:0] ra,
  input  logic [NREAD*DW-1:0]    rf_data,
  input  logic [NBYP-1:0]        byp_valid,
  input  logic [NBYP*REG_AW-1:0] byp_addr,
  input  logic [NBYP*DW-1:0]     byp_data,
  input  logic [NBYP-1:0]        byp_ready,
  input  logic                   wb_valid,
  input  logic [REG_AW-1:0]      wb_addr,
`ifdef HILO_TRACK_EN
  input  logic                   issue_hi_w,
  input  logic                   issue_lo_w,
  input  logic                   wb_hi,
  input  logic                   wb_lo,
  input  logic [NREAD-1:0]       rd_hi,
  input  logic [NREAD-1:0]       rd_lo,
  input  logic [NBYP-1:0]        byp_hi,
  input  logic [NBYP-1:0]        byp_lo,
`endif
  output logic [NREAD*DW-1:0]    opnd,
  output logic                   stall,
  output logic                   issue_fire
);

  localparam int NREGS = 1 << REG_AW;
`ifdef HILO_TRACK_EN
  localparam int HI_IDX = NREGS;
  localparam int LO_IDX = NREGS + 1;
  localparam int NENT   = NREGS + 2;
`else
  localparam int NENT   = NREGS;
`endif
  localparam int ENT_W = $clog2(NENT);

  logic [NENT-1:0]  set_vec, clr_vec, pend_vec;
  logic [LAT_W-1:0] cnt_arr [NENT];
  logic [NREAD-1:0] hazard;

  logic [REG_AW-1:0] port_addr;
  logic [ENT_W-1:0]  port_ent;
  logic              port_zero, found, byp_match;

  // Register 0 is never marked pending; its set/clear strobes stay low.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_fire && issue_wen && (issue_waddr != REG_AW'(REG_ZERO))) begin
      set_vec[ENT_W'(issue_waddr)] = 1'b1;
    end
    if (wb_valid && (wb_addr != REG_AW'(REG_ZERO))) begin
      clr_vec[ENT_W'(wb_addr)] = 1'b1;
    end
`ifdef HILO_TRACK_EN
    if (issue_fire && issue_hi_w) set_vec[HI_IDX] = 1'b1;
    if (issue_fire && issue_lo_w) set_vec[LO_IDX] = 1'b1;
    if (wb_hi) clr_vec[HI_IDX] = 1'b1;
    if (wb_lo) clr_vec[LO_IDX] = 1'b1;
`endif
  end

  // NOTE: the pending table is flops, not RAM, so an async reset can discard every entry at once.
  for (genvar g = 0; g < NENT; g++) begin : g_ent
    pend_entry #(.LAT_W(LAT_W)) u_entry (
      .clk    (clk),
      .resetn (resetn),
      .flush_i(flush),
      .set_i  (set_vec[g]),
      .lat_i  (issue_lat),
      .clr_i  (clr_vec[g]),
      .pend_o (pend_vec[g]),
      .cnt_o  (cnt_arr[g])
    );
  end

  // Per port: youngest matching bypass wins; otherwise the table decides.
  always_comb begin
    opnd      = '0;
    hazard    = '0;
    port_addr = '0;
    port_ent  = '0;
    port_zero = 1'b0;
    found     = 1'b0;
    byp_match = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      port_addr = ra[p*REG_AW +: REG_AW];
      port_ent  = ENT_W'(port_addr);
      port_zero = (port_addr == REG_AW'(REG_ZERO));
`ifdef HILO_TRACK_EN
      if (rd_hi[p]) begin
        port_ent  = ENT_W'(HI_IDX);
        port_zero = 1'b0;
      end else if (rd_lo[p]) begin
        port_ent  = ENT_W'(LO_IDX);
        port_zero = 1'b0;
      end
`endif
      found = 1'b0;
      if (!port_zero) begin
        for (int i = 0; i < NBYP; i++) begin
          byp_match = byp_valid[i] && (byp_addr[i*REG_AW +: REG_AW] == port_addr);
`ifdef HILO_TRACK_EN
          if (rd_hi[p]) begin
            byp_match = byp_valid[i] && byp_hi[i];
          end else if (rd_lo[p]) begin
            byp_match = byp_valid[i] && byp_lo[i];
          end
`endif
          if (!found && byp_match) begin
            found = 1'b1;
            if (byp_ready[i]) begin
              opnd[p*DW +: DW] = byp_data[i*DW +: DW];
            end else begin
              hazard[p] = 1'b1;
            end
          end
        end
        if (!found) begin
          opnd[p*DW +: DW] = rf_data[p*DW +: DW];
          if (pend_vec[port_ent] && (cnt_arr[port_ent] != '0)) begin
            hazard[p] = 1'b1;
          end
        end
      end
    end
  end

  assign stall      = issue_valid & (|hazard);
  assign issue_fire = issue_valid & ~stall;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected outputs are queued with
// each stimulus step and popped/compared once the combinational outputs settle.
module tb_hazard_scoreboard;

  localparam int NREAD  = 2;
  localparam int NBYP   = 2;
  localparam int REG_AW = 5;
  localparam int DW     = 32;
  localparam int LAT_W  = 3;

  localparam logic [DW-1:0] RF0 = 32'hAAAA_0000;
  localparam logic [DW-1:0] RF1 = 32'hBBBB_0001;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic                    flush;
  logic                    issue_valid;
  logic                    issue_wen;
  logic [REG_AW-1:0]       issue_waddr;
  logic [LAT_W-1:0]        issue_lat;
  logic [NREAD*REG_AW-1:0] ra;
  logic [NREAD*DW-1:0]     rf_data;
  logic [NBYP-1:0]         byp_valid;
  logic [NBYP*REG_AW-1:0]  byp_addr;
  logic [NBYP*DW-1:0]      byp_data;
  logic [NBYP-1:0]         byp_ready;
  logic                    wb_valid;
  logic [REG_AW-1:0]       wb_addr;
  logic [NREAD*DW-1:0]     opnd;
  logic                    stall;
  logic                    issue_fire;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string           tag;
    logic            stall;
    logic            fire;
    logic [1:0]      chk;
    logic [DW-1:0]   op0;
    logic [DW-1:0]   op1;
  } exp_t;

  exp_t sb_q[$];

  hazard_scoreboard #(
    .NREAD(NREAD), .NBYP(NBYP), .REG_AW(REG_AW), .DW(DW), .LAT_W(LAT_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .issue_valid(issue_valid),
    .issue_wen  (issue_wen),
    .issue_waddr(issue_waddr),
    .issue_lat  (issue_lat),
    .ra         (ra),
    .rf_data    (rf_data),
    .byp_valid  (byp_valid),
    .byp_addr   (byp_addr),
    .byp_data   (byp_data),
    .byp_ready  (byp_ready),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .opnd       (opnd),
    .stall      (stall),
    .issue_fire (issue_fire)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_wen   = 1'b0;
    issue_waddr = '0;
    issue_lat   = '0;
    ra          = '0;
    rf_data     = {RF1, RF0};
    byp_valid   = '0;
    byp_addr    = '0;
    byp_data    = '0;
    byp_ready   = '0;
    wb_valid    = 1'b0;
    wb_addr     = '0;
  endtask

  task automatic next();
    @(negedge clk);
    idle();
  endtask

  task automatic set_ra(input logic [REG_AW-1:0] a0, input logic [REG_AW-1:0] a1);
    ra = {a1, a0};
  endtask

  task automatic set_byp(input int i, input logic [REG_AW-1:0] a, input logic [DW-1:0] d,
                         input logic rdy);
    byp_valid[i]              = 1'b1;
    byp_addr[i*REG_AW +: REG_AW] = a;
    byp_data[i*DW +: DW]      = d;
    byp_ready[i]              = rdy;
  endtask

  task automatic issue(input logic [REG_AW-1:0] a, input logic [LAT_W-1:0] lat);
    issue_valid = 1'b1;
    issue_wen   = 1'b1;
    issue_waddr = a;
    issue_lat   = lat;
  endtask

  task automatic expect_out(input string tag, input logic st, input logic [1:0] chk,
                            input logic [DW-1:0] op0, input logic [DW-1:0] op1);
    exp_t e;
    e.tag   = tag;
    e.stall = st;
    e.fire  = issue_valid & ~st;
    e.chk   = chk;
    e.op0   = op0;
    e.op1   = op1;
    sb_q.push_back(e);
  endtask

  task automatic compare_now();
    exp_t e;
    #1;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({e.tag, ".stall"}, DW'(stall), DW'(e.stall));
      check({e.tag, ".fire"}, DW'(issue_fire), DW'(e.fire));
      if (e.chk[0]) check({e.tag, ".op0"}, opnd[0 +: DW], e.op0);
      if (e.chk[1]) check({e.tag, ".op1"}, opnd[DW +: DW], e.op1);
    end
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    #3;
    expect_out("rst_idle", 1'b0, 2'b00, '0, '0);
    compare_now();
    issue_valid = 1'b1;
    set_ra(5'd3, 5'd1);
    expect_out("rst_read", 1'b0, 2'b11, RF0, RF1);
    compare_now();
    next();
    resetn = 1'b1;

    // Execute-stage bypass, priority and load-use
    next(); issue_valid = 1'b1; set_ra(5'd3, 5'd0); set_byp(0, 5'd3, 32'h11, 1'b1);
    expect_out("b2b", 1'b0, 2'b11, 32'h11, '0); compare_now();
    next(); issue_valid = 1'b1; set_ra(5'd6, 5'd6);
    set_byp(0, 5'd6, 32'h66, 1'b1); set_byp(1, 5'd6, 32'h77, 1'b1);
    expect_out("youngest_wins", 1'b0, 2'b11, 32'h66, 32'h66); compare_now();
    next(); issue_valid = 1'b1; set_ra(5'd6, 5'd1);
    set_byp(0, 5'd6, 32'h66, 1'b0); set_byp(1, 5'd6, 32'h77, 1'b1);
    expect_out("young_not_ready", 1'b1, 2'b10, '0, RF1); compare_now();
    next(); issue_valid = 1'b1; set_ra(5'd5, 5'd0); set_byp(0, 5'd5, 32'h1234, 1'b0);
    expect_out("load_use", 1'b1, 2'b10, '0, '0); compare_now();
    next(); issue_valid = 1'b1; set_ra(5'd5, 5'd0); set_byp(1, 5'd5, 32'hDEAD, 1'b1);
    expect_out("load_use_mem", 1'b0, 2'b11, 32'hDEAD, '0); compare_now();

    // Long latency producer on r7
    next(); issue(5'd7, 3'd5); set_ra(5'd1, 5'd2);
    expect_out("issue_r7", 1'b0, 2'b11, RF0, RF1); compare_now();
    for (int k = 0; k < 5; k++) begin
      next(); issue_valid = 1'b1; set_ra(5'd7, 5'd0);
      expect_out($sformatf("r7_wait%0d", k), 1'b1, 2'b10, '0, '0); compare_now();
    end
    next(); issue_valid = 1'b1; set_ra(5'd7, 5'd0);
    expect_out("r7_rf", 1'b0, 2'b11, RF0, '0); compare_now();

    // Writeback clears a pending entry from the next cycle on
    next(); issue(5'd11, 3'd2); set_ra(5'd1, 5'd0);
    expect_out("issue_r11", 1'b0, 2'b11, RF0, '0); compare_now();
    next(); issue_valid = 1'b1; set_ra(5'd11, 5'd0); wb_valid = 1'b1; wb_addr = 5'd11;
    expect_out("wb_same_cycle", 1'b1, 2'b10, '0, '0); compare_now();
    next(); issue_valid = 1'b1; set_ra(5'd11, 5'd0);
    expect_out("wb_cleared", 1'b0, 2'b11, RF0, '0); compare_now();

    // Zero latency: bypassable next cycle
    next(); issue(5'd8, 3'd0); set_ra(5'd1, 5'd0);
    expect_out("issue_r8", 1'b0, 2'b11, RF0, '0); compare_now();
    next(); issue_valid = 1'b1; set_ra(5'd8, 5'd0);
    expect_out("lat0_read", 1'b0, 2'b11, RF0, '0); compare_now();

    // Re-issue with simultaneous writeback to r9 restarts the countdown
    next(); issue(5'd9, 3'd3); set_ra(5'd1, 5'd0);
    expect_out("issue_r9a", 1'b0, 2'b11, RF0, '0); compare_now();
    next(); issue(5'd9, 3'd4); set_ra(5'd1, 5'd0); wb_valid = 1'b1; wb_addr = 5'd9;
    expect_out("issue_r9b_wb", 1'b0, 2'b11, RF0, '0); compare_now();
    for (int k = 0; k < 4; k++) begin
      next(); issue_valid = 1'b1; set_ra(5'd9, 5'd0);
      expect_out($sformatf("r9_wait%0d", k), 1'b1, 2'b10, '0, '0); compare_now();
    end
    next(); issue_valid = 1'b1; set_ra(5'd9, 5'd0);
    expect_out("r9_rf", 1'b0, 2'b11, RF0, '0); compare_now();

    // Maximum latency on r10; one idle-decode cycle inside the wait
    next(); issue(5'd10, 3'd7); set_ra(5'd1, 5'd0);
    expect_out("issue_r10", 1'b0, 2'b11, RF0, '0); compare_now();
    for (int k = 0; k < 7; k++) begin
      next(); issue_valid = (k != 3); set_ra(5'd0, 5'd10);
      expect_out($sformatf("r10_wait%0d", k), (k != 3), 2'b01, '0, '0); compare_now();
    end
    next(); issue_valid = 1'b1; set_ra(5'd0, 5'd10);
    expect_out("r10_rf", 1'b0, 2'b11, '0, RF1); compare_now();

    // Register 0 never hazards and reads as zero
    next(); issue(5'd0, 3'd5); set_ra(5'd0, 5'd0); set_byp(0, 5'd0, 32'h55, 1'b0);
    expect_out("r0_byp", 1'b0, 2'b11, '0, '0); compare_now();
    next(); issue_valid = 1'b1; set_ra(5'd0, 5'd0);
    expect_out("r0_after_issue", 1'b0, 2'b11, '0, '0); compare_now();

    // Flush with r2 and r4 pending; same-cycle issue of r12 is dropped
    next(); issue(5'd2, 3'd6); set_ra(5'd1, 5'd0);
    expect_out("issue_r2", 1'b0, 2'b11, RF0, '0); compare_now();
    next(); issue(5'd4, 3'd6); set_ra(5'd1, 5'd0);
    expect_out("issue_r4", 1'b0, 2'b11, RF0, '0); compare_now();
    next(); issue_valid = 1'b1; set_ra(5'd2, 5'd4);
    expect_out("pre_flush", 1'b1, 2'b00, '0, '0); compare_now();
    next(); issue(5'd12, 3'd5); flush = 1'b1; set_ra(5'd1, 5'd0);
    expect_out("flush_cycle", 1'b0, 2'b11, RF0, '0); compare_now();
    next(); issue_valid = 1'b1; set_ra(5'd2, 5'd4);
    expect_out("post_flush", 1'b0, 2'b11, RF0, RF1); compare_now();
    next(); issue_valid = 1'b1; set_ra(5'd12, 5'd0);
    expect_out("flush_drop_issue", 1'b0, 2'b11, RF0, '0); compare_now();

    // Async reset pulse mid-countdown
    next(); issue(5'd2, 3'd6); set_ra(5'd1, 5'd0);
    expect_out("reissue_r2", 1'b0, 2'b11, RF0, '0); compare_now();
    next(); issue(5'd4, 3'd6); set_ra(5'd1, 5'd0);
    expect_out("reissue_r4", 1'b0, 2'b11, RF0, '0); compare_now();
    next(); issue_valid = 1'b1; set_ra(5'd2, 5'd4);
    expect_out("pre_reset", 1'b1, 2'b00, '0, '0); compare_now();
    #2 resetn = 1'b0;
    #1 resetn = 1'b1;
    next(); issue_valid = 1'b1; set_ra(5'd2, 5'd4);
    expect_out("post_reset", 1'b0, 2'b11, RF0, RF1); compare_now();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
